// File: rtl/demux16_dispatch_ctrl_if.sv
// Dispatch bus for demux16_dispatch_ctrl: upstream valid/ready word channel
// plus the registered select/data/one-hot valid lanes toward the 16 sinks.
// The slave modport is the controller's view; master is the producer/sink side.
interface demux16_dispatch_ctrl_if #(
  parameter int unsigned DATA_W = 8
);
  // Upstream word channel
  logic              s_valid;
  logic              s_ready;
  logic [3:0]        s_dest;
  logic [DATA_W-1:0] s_data;

  // Demux output lanes
  logic [3:0]        sel;
  logic [DATA_W-1:0] m_data;
  logic [15:0]       m_valid;
  logic [15:0]       m_ready;

  modport slave (
    input  s_valid,
    output s_ready,
    input  s_dest,
    input  s_data,
    output sel,
    output m_data,
    output m_valid,
    input  m_ready
  );

  modport master (
    output s_valid,
    input  s_ready,
    output s_dest,
    output s_data,
    input  sel,
    input  m_data,
    input  m_valid,
    output m_ready
  );
endinterface

// File: rtl/demux16_dispatch_ctrl.sv
// Single-beat dispatch controller for the 1:16 demux fabric.
// Accepts one word with a 4-bit destination, presents it to the addressed sink
// with a one-hot valid, and holds it until the sink accepts or a timeout fires.
// Timed-out words are dropped and counted in a saturating 8-bit counter.
// Optional build macro DEMUX_MASK_EN adds a per-sink enable input dest_en;
// words to disabled sinks are dropped at acceptance without being presented.
module demux16_dispatch_ctrl #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                         clk,
  input  logic                         rst_n,
  demux16_dispatch_ctrl_if.slave       bus,
`ifdef DEMUX_MASK_EN
  input  logic [15:0]                  dest_en,
`endif
  output logic                         busy,
  output logic                         drop_pulse,
  output logic [7:0]                   drop_cnt
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  // Last counter value before a drop; TIMEOUT is limited to 1..255.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [3:0]        sel_q, sel_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [15:0]       m_valid_q, m_valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              drop_pulse_q, drop_pulse_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic              dest_ok;
  logic              do_drop;
  logic              s_fire;

`ifdef DEMUX_MASK_EN
  // Enable is sampled only at acceptance; SEND ignores later changes.
  assign dest_ok = dest_en[bus.s_dest];
`else
  assign dest_ok = 1'b1;
`endif

  assign bus.s_ready = (state_q == StIdle);
  assign s_fire      = bus.s_valid & bus.s_ready;

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      sel_q        <= 4'd0;
      m_data_q     <= '0;
      m_valid_q    <= 16'd0;
      cnt_q        <= 8'd0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= 8'd0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      m_data_q     <= m_data_d;
      m_valid_q    <= m_valid_d;
      cnt_q        <= cnt_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Next-state logic: accept in IDLE, deliver or time out in SEND.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    m_data_d     = m_data_q;
    m_valid_d    = m_valid_q;
    cnt_d        = cnt_q;
    drop_pulse_d = 1'b0;
    drop_cnt_d   = drop_cnt_q;
    do_drop      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (s_fire) begin
          if (dest_ok) begin
            sel_d     = bus.s_dest;
            m_data_d  = bus.s_data;
            m_valid_d = 16'd1 << bus.s_dest;
            cnt_d     = 8'd0;
            state_d   = StSend;
          end else begin
            // Masked destination: word is consumed but never presented.
            do_drop = 1'b1;
          end
        end
      end
      StSend: begin
        // Acceptance takes priority over a coincident timeout.
        if (bus.m_ready[sel_q]) begin
          m_valid_d = 16'd0;
          state_d   = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          m_valid_d = 16'd0;
          state_d   = StIdle;
          do_drop   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        m_valid_d = 16'd0;
        state_d   = StIdle;
      end
    endcase

    if (do_drop) begin
      drop_pulse_d = 1'b1;
      if (drop_cnt_q != 8'hFF) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  // Output wiring from registered state.
  always_comb begin
    bus.sel     = sel_q;
    bus.m_data  = m_data_q;
    bus.m_valid = m_valid_q;
    busy        = (state_q == StSend);
    drop_pulse  = drop_pulse_q;
    drop_cnt    = drop_cnt_q;
  end

`ifndef SYNTHESIS
  // Structural invariants of the output lanes.
  a_valid_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(m_valid_q));
  a_idle_no_valid : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StIdle) |-> (m_valid_q == 16'd0));
  a_send_valid_sel : assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StSend) |-> (m_valid_q == (16'd1 << sel_q)));
`endif

endmodule

// File: tb/tb_demux16_dispatch_ctrl.sv
// Directed self-checking bench for demux16_dispatch_ctrl (TIMEOUT = 15).
module tb_demux16_dispatch_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned TO     = 15;

  logic       clk;
  logic       rst_n;
  logic       busy;
  logic       drop_pulse;
  logic [7:0] drop_cnt;
`ifdef DEMUX_MASK_EN
  logic [15:0] dest_en;
`endif

  int n_checks;
  int n_pass;

  demux16_dispatch_ctrl_if #(.DATA_W(DATA_W)) bus ();

  demux16_dispatch_ctrl #(
    .DATA_W  (DATA_W),
    .TIMEOUT (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
`ifdef DEMUX_MASK_EN
    .dest_en    (dest_en),
`endif
    .busy       (busy),
    .drop_pulse (drop_pulse),
    .drop_cnt   (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; sample and drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one word for a single accept edge.
  task automatic send_word(input logic [3:0] dest, input logic [7:0] data);
    bus.s_valid = 1'b1;
    bus.s_dest  = dest;
    bus.s_data  = data;
    tick();
    bus.s_valid = 1'b0;
  endtask

  // Stimulus only: one word to sink 9 that nobody accepts.
  task automatic force_timeout();
    bus.m_ready = 16'h0000;
    send_word(4'd9, 8'h55);
    repeat (TO) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL reset_s_ready got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (bus.sel !== 4'd0) $display("FAIL reset_sel got %0d want 0", bus.sel); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL reset_m_data got %h want 00", bus.m_data); else n_pass++;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL reset_m_valid got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b0) $display("FAIL reset_drop_pulse got %b want 0", drop_pulse); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    bus.m_ready = 16'h0000;
    send_word(4'd5, 8'hA3);
    n_checks++; if (bus.m_valid !== 16'h0020) $display("FAIL basic_m_valid got %h want 0020", bus.m_valid); else n_pass++;
    n_checks++; if (bus.sel !== 4'd5) $display("FAIL basic_sel got %0d want 5", bus.sel); else n_pass++;
    n_checks++; if (bus.m_data !== 8'hA3) $display("FAIL basic_m_data got %h want a3", bus.m_data); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b0) $display("FAIL basic_s_ready got %b want 0", bus.s_ready); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy got %b want 1", busy); else n_pass++;
    bus.m_ready = 16'h0020;
    tick();
    bus.m_ready = 16'h0000;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL basic_done_m_valid got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL basic_done_s_ready got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL basic_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
    n_checks++; if (bus.sel !== 4'd5) $display("FAIL basic_sel_kept got %0d want 5", bus.sel); else n_pass++;
  endtask

  task automatic test_sweep();
    logic [15:0] exp_v;
    logic [7:0]  exp_d;
    int          pulses;
    pulses = 0;
    for (int d = 0; d < 16; d++) begin
      exp_v = 16'd1 << d;
      exp_d = 8'(8'h10 + d);
      bus.m_ready = exp_v;
      send_word(4'(d), exp_d);
      n_checks++; if (bus.m_valid !== exp_v) $display("FAIL sweep_m_valid d=%0d got %h want %h", d, bus.m_valid, exp_v); else n_pass++;
      n_checks++; if (bus.m_data !== exp_d) $display("FAIL sweep_m_data d=%0d got %h want %h", d, bus.m_data, exp_d); else n_pass++;
      if (drop_pulse === 1'b1) pulses++;
      tick();
      n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL sweep_s_ready d=%0d got %b want 1", d, bus.s_ready); else n_pass++;
      if (drop_pulse === 1'b1) pulses++;
    end
    bus.m_ready = 16'h0000;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL sweep_end_m_valid got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (pulses !== 0) $display("FAIL sweep_drop_pulses got %0d want 0", pulses); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL sweep_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
  endtask

  // Count cycles m_valid stays at want, bounded so a stuck DUT still ends.
  task automatic count_valid(input logic [15:0] want, output int cycles);
    cycles = 0;
    while (bus.m_valid === want && cycles < 40) begin
      cycles++;
      tick();
    end
  endtask

  task automatic test_timeout();
    int cyc;
    bus.m_ready = 16'h0000;
    send_word(4'd9, 8'h77);
    count_valid(16'h0200, cyc);
    n_checks++; if (cyc !== 15) $display("FAIL timeout_valid_cycles got %0d want 15", cyc); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b1) $display("FAIL timeout_drop_pulse got %b want 1", drop_pulse); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd1) $display("FAIL timeout_drop_cnt got %0d want 1", drop_cnt); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL timeout_s_ready got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (bus.sel !== 4'd9) $display("FAIL timeout_sel_kept got %0d want 9", bus.sel); else n_pass++;
    tick();
    n_checks++; if (drop_pulse !== 1'b0) $display("FAIL timeout_pulse_width got %b want 0", drop_pulse); else n_pass++;
  endtask

  task automatic test_wrong_ready();
    int cyc;
    bus.m_ready = 16'h0008;
    send_word(4'd9, 8'h66);
    count_valid(16'h0200, cyc);
    n_checks++; if (cyc !== 15) $display("FAIL wrong_ready_cycles got %0d want 15", cyc); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL wrong_ready_drop_cnt got %0d want 2", drop_cnt); else n_pass++;
    tick();
    // Second word: the correct ready arrives on the final counter cycle.
    send_word(4'd9, 8'h99);
    repeat (14) tick();
    n_checks++; if (bus.m_valid !== 16'h0200) $display("FAIL last_cycle_m_valid got %h want 0200", bus.m_valid); else n_pass++;
    bus.m_ready = 16'h0208;
    tick();
    bus.m_ready = 16'h0000;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL last_cycle_done got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b0) $display("FAIL last_cycle_pulse got %b want 0", drop_pulse); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd2) $display("FAIL last_cycle_drop_cnt got %0d want 2", drop_cnt); else n_pass++;
  endtask

`ifdef DEMUX_MASK_EN
  task automatic test_mask();
    dest_en = 16'hFFFE;
    bus.m_ready = 16'h0000;
    send_word(4'd0, 8'h11);
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL mask_m_valid got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL mask_s_ready got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b1) $display("FAIL mask_drop_pulse got %b want 1", drop_pulse); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd3) $display("FAIL mask_drop_cnt got %0d want 3", drop_cnt); else n_pass++;
    send_word(4'd1, 8'h22);
    n_checks++; if (bus.m_valid !== 16'h0002) $display("FAIL mask_dest1 got %h want 0002", bus.m_valid); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h22) $display("FAIL mask_dest1_data got %h want 22", bus.m_data); else n_pass++;
    dest_en = 16'h0000;
    bus.m_ready = 16'h0002;
    tick();
    bus.m_ready = 16'h0000;
    dest_en = 16'hFFFF;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL mask_dest1_done got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd3) $display("FAIL mask_dest1_drop_cnt got %0d want 3", drop_cnt); else n_pass++;
  endtask
`endif

  task automatic test_saturation();
    int base;
    base = int'(drop_cnt);
    for (int i = 0; i < 260; i++) begin
      force_timeout();
      if (base + i + 1 == 254) begin
        n_checks++; if (drop_cnt !== 8'd254) $display("FAIL sat_pre got %0d want 254", drop_cnt); else n_pass++;
      end
    end
    n_checks++; if (drop_cnt !== 8'd255) $display("FAIL sat_final got %0d want 255", drop_cnt); else n_pass++;
    n_checks++; if (drop_pulse !== 1'b1) $display("FAIL sat_pulse got %b want 1", drop_pulse); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_send();
    bus.m_ready = 16'h0000;
    send_word(4'd4, 8'hC4);
    tick();
    tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL mid_send_busy got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.m_valid !== 16'h0000) $display("FAIL rst_mid_m_valid got %h want 0000", bus.m_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (bus.s_ready !== 1'b1) $display("FAIL rst_mid_s_ready got %b want 1", bus.s_ready); else n_pass++;
    n_checks++; if (bus.sel !== 4'd0) $display("FAIL rst_mid_sel got %0d want 0", bus.sel); else n_pass++;
    n_checks++; if (bus.m_data !== 8'h00) $display("FAIL rst_mid_m_data got %h want 00", bus.m_data); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_mid_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
    tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_checks++; if (drop_pulse !== 1'b0) $display("FAIL rst_after_pulse got %b want 0", drop_pulse); else n_pass++;
    n_checks++; if (drop_cnt !== 8'd0) $display("FAIL rst_after_drop_cnt got %0d want 0", drop_cnt); else n_pass++;
  endtask

  initial begin
    n_checks    = 0;
    n_pass      = 0;
    rst_n       = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_dest  = 4'd0;
    bus.s_data  = 8'h00;
    bus.m_ready = 16'h0000;
`ifdef DEMUX_MASK_EN
    dest_en     = 16'hFFFF;
`endif
    #3;
    test_reset();
    test_basic();
    test_sweep();
    test_timeout();
    test_wrong_ready();
`ifdef DEMUX_MASK_EN
    test_mask();
`endif
    test_saturation();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
